// File: rtl/anc_frame_sched.sv
// Per-sample frame sequencer for the adaptive ANC datapath: xn write, FIR tap
// sweep, then LMS read-modify-write sweep, with overrun detection and frame count.
module anc_frame_sched #(
    parameter int TAPS   = 126,
    parameter int ADDR_W = 7,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_sample_stb,
    input  logic              i_overrun_clr,
    output logic              o_busy,
    output logic              o_xn_wren,
    output logic [ADDR_W-1:0] o_xn_addr,
    output logic [ADDR_W-1:0] o_wz_rd_addr,
    output logic              o_fir_acc_clr,
    output logic              o_fir_acc_en,
    output logic              o_fir_done,
    output logic              o_lms_mul_en,
    output logic              o_wz_wren,
    output logic [ADDR_W-1:0] o_wz_wr_addr,
    output logic              o_frame_done,
    output logic              o_overrun,
    output logic [11:0]       o_frame_cnt
);

    typedef enum logic [2:0] {IDLE, LOAD, FIR, FIR_DRAIN, LMS, LMS_DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_TAP    = ADDR_W'(TAPS - 1);
    localparam logic [ADDR_W-1:0] FDRAIN_LAST = ADDR_W'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] LDRAIN_LAST = ADDR_W'(RD_LAT);

    state_t                         r_state, w_state_nxt;
    logic [ADDR_W-1:0]              r_tap, w_tap_nxt;
    logic [ADDR_W-1:0]              r_xn_base, r_xn_hold, r_wz_hold, w_xn_tap;
    logic                           w_sweep;
    logic [11:0]                    r_frame_cnt;
    logic                           r_overrun;
    logic [RD_LAT:1]                r_fir_vld;
    logic [RD_LAT+1:1]              r_lms_vld;
    logic [RD_LAT+1:1][ADDR_W-1:0]  r_lms_addr;

    assign w_sweep = (r_state == FIR) || (r_state == LMS);

    // (base - tap) mod TAPS; ADDR_W-bit wraparound cancels out since the result is < TAPS
    assign w_xn_tap = (r_xn_base < r_tap) ? r_xn_base + ADDR_W'(TAPS) - r_tap
                                          : r_xn_base - r_tap;

    always_comb begin
        w_state_nxt = r_state;
        w_tap_nxt   = r_tap;
        case (r_state)
            IDLE:      if (i_sample_stb && i_enable) w_state_nxt = LOAD;
            LOAD:      begin w_state_nxt = FIR; w_tap_nxt = '0; end
            FIR:       if (r_tap == LAST_TAP) begin w_state_nxt = FIR_DRAIN; w_tap_nxt = '0; end
                       else w_tap_nxt = r_tap + 1'b1;
            FIR_DRAIN: if (r_tap == FDRAIN_LAST) begin w_state_nxt = LMS; w_tap_nxt = '0; end
                       else w_tap_nxt = r_tap + 1'b1;
            LMS:       if (r_tap == LAST_TAP) begin w_state_nxt = LMS_DRAIN; w_tap_nxt = '0; end
                       else w_tap_nxt = r_tap + 1'b1;
            LMS_DRAIN: if (r_tap == LDRAIN_LAST) begin w_state_nxt = DONE; w_tap_nxt = '0; end
                       else w_tap_nxt = r_tap + 1'b1;
            DONE:      w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busy        = (r_state != IDLE);
        o_xn_wren     = (r_state == LOAD);
        o_fir_acc_clr = (r_state == LOAD);
        o_frame_done  = (r_state == DONE);
        o_fir_done    = (r_state == LMS) && (r_tap == '0);
        o_xn_addr     = r_xn_hold;
        o_wz_rd_addr  = r_wz_hold;
        if (r_state == LOAD) o_xn_addr = r_xn_base;
        if (w_sweep) begin
            o_xn_addr    = w_xn_tap;
            o_wz_rd_addr = r_tap;
        end
        o_fir_acc_en  = r_fir_vld[RD_LAT];
        o_lms_mul_en  = r_lms_vld[RD_LAT];
        o_wz_wren     = r_lms_vld[RD_LAT+1];
        o_wz_wr_addr  = r_lms_addr[RD_LAT+1];
        o_overrun     = r_overrun;
        o_frame_cnt   = r_frame_cnt;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_tap       <= '0;
            r_xn_base   <= '0;
            r_xn_hold   <= '0;
            r_wz_hold   <= '0;
            r_frame_cnt <= '0;
            r_overrun   <= 1'b0;
            r_fir_vld   <= '0;
            r_lms_vld   <= '0;
            r_lms_addr  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tap     <= w_tap_nxt;
            r_xn_hold <= o_xn_addr;
            r_wz_hold <= o_wz_rd_addr;
            if (r_state == DONE) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
                r_xn_base   <= (r_xn_base == LAST_TAP) ? '0 : r_xn_base + 1'b1;
            end
            // a dropped strobe takes priority over a coincident clear
            if (i_sample_stb && r_state != IDLE) r_overrun <= 1'b1;
            else if (i_overrun_clr)              r_overrun <= 1'b0;
            r_fir_vld[1] <= (r_state == FIR);
            for (int s = 2; s <= RD_LAT; s++) r_fir_vld[s] <= r_fir_vld[s-1];
            r_lms_vld[1] <= (r_state == LMS);
            if (r_state == LMS) r_lms_addr[1] <= r_tap;
            for (int s = 2; s <= RD_LAT + 1; s++) begin
                r_lms_vld[s]  <= r_lms_vld[s-1];
                r_lms_addr[s] <= r_lms_addr[s-1];
            end
        end
    end

endmodule

// File: tb/tb_anc_frame_sched.sv
// Directed bench for anc_frame_sched: frame timing, xn wrap, overrun, enable, reset, RD_LAT=2.
module tb_anc_frame_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0, sample_stb = 1'b0, overrun_clr = 1'b0;
    logic       busy, xn_wren, fir_acc_clr, fir_acc_en, fir_done, lms_mul_en, wz_wren, frame_done, overrun;
    logic [6:0] xn_addr, wz_rd_addr, wz_wr_addr;
    logic [11:0] frame_cnt;
    logic       d2_busy, d2_xn_wren, d2_fir_acc_clr, d2_fir_acc_en, d2_fir_done, d2_lms_mul_en, d2_wz_wren;
    logic       d2_frame_done, d2_overrun;
    logic [6:0] d2_xn_addr, d2_wz_rd_addr, d2_wz_wr_addr;
    logic [11:0] d2_frame_cnt;

    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    anc_frame_sched #(.TAPS(126), .ADDR_W(7), .RD_LAT(1)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_sample_stb(sample_stb),
        .i_overrun_clr(overrun_clr), .o_busy(busy), .o_xn_wren(xn_wren), .o_xn_addr(xn_addr),
        .o_wz_rd_addr(wz_rd_addr), .o_fir_acc_clr(fir_acc_clr), .o_fir_acc_en(fir_acc_en),
        .o_fir_done(fir_done), .o_lms_mul_en(lms_mul_en), .o_wz_wren(wz_wren),
        .o_wz_wr_addr(wz_wr_addr), .o_frame_done(frame_done), .o_overrun(overrun),
        .o_frame_cnt(frame_cnt));

    anc_frame_sched #(.TAPS(126), .ADDR_W(7), .RD_LAT(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_sample_stb(sample_stb),
        .i_overrun_clr(overrun_clr), .o_busy(d2_busy), .o_xn_wren(d2_xn_wren), .o_xn_addr(d2_xn_addr),
        .o_wz_rd_addr(d2_wz_rd_addr), .o_fir_acc_clr(d2_fir_acc_clr), .o_fir_acc_en(d2_fir_acc_en),
        .o_fir_done(d2_fir_done), .o_lms_mul_en(d2_lms_mul_en), .o_wz_wren(d2_wz_wren),
        .o_wz_wr_addr(d2_wz_wr_addr), .o_frame_done(d2_frame_done), .o_overrun(d2_overrun),
        .o_frame_cnt(d2_frame_cnt));

    // per-offset trace of one frame, offset 0 = strobe cycle
    logic [299:0] v_busy, v_xwr, v_clr, v_acc, v_fdn, v_mul, v_wwr, v_done;
    logic [299:0] w_acc, w_fdn, w_mul, w_wwr, w_done;
    int xn_at [0:299];
    int wzr_at[0:299];
    int wz_seq_err, wz_next;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int first1(input logic [299:0] v);
        for (int i = 0; i < 300; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int last1(input logic [299:0] v);
        for (int i = 299; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int cnt1(input logic [299:0] v);
        int c = 0;
        for (int i = 0; i < 300; i++) if (v[i]) c++;
        return c;
    endfunction

    // sample at each negedge, then drive the inputs for that cycle
    task automatic capture(input int n, input int stb_a, input int stb_b, input int clr_a, input int en_off);
        v_busy = '0; v_xwr = '0; v_clr = '0; v_acc = '0; v_fdn = '0; v_mul = '0; v_wwr = '0; v_done = '0;
        w_acc = '0; w_fdn = '0; w_mul = '0; w_wwr = '0; w_done = '0;
        wz_seq_err = 0; wz_next = 0;
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            v_busy[j] = busy;   v_xwr[j] = xn_wren;  v_clr[j] = fir_acc_clr; v_acc[j] = fir_acc_en;
            v_fdn[j]  = fir_done; v_mul[j] = lms_mul_en; v_wwr[j] = wz_wren; v_done[j] = frame_done;
            w_acc[j] = d2_fir_acc_en; w_fdn[j] = d2_fir_done; w_mul[j] = d2_lms_mul_en;
            w_wwr[j] = d2_wz_wren; w_done[j] = d2_frame_done;
            xn_at[j]  = int'(xn_addr);
            wzr_at[j] = int'(wz_rd_addr);
            if (wz_wren) begin
                if (int'(wz_wr_addr) != wz_next) wz_seq_err++;
                wz_next++;
            end
            sample_stb  = (j == stb_a) || (j == stb_b);
            overrun_clr = (j == clr_a);
            if (j == en_off) enable = 1'b0;
        end
    endtask

    initial begin
        int wr_after;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_xn_addr", xn_addr, 0);
        chk("rst_wz_wren", wz_wren, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_overrun", overrun, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;
        repeat (2) @(negedge clk);

        // single frame, RD_LAT=1 and RD_LAT=2 side by side
        sample_stb = 1'b1;
        capture(262, 0, 0, 0, 0);
        chk("f1_xwr_at",   first1(v_xwr), 1);
        chk("f1_xwr_cnt",  cnt1(v_xwr), 1);
        chk("f1_xwr_addr", xn_at[1], 0);
        chk("f1_clr_at",   first1(v_clr), 1);
        chk("f1_acc_first", first1(v_acc), 3);
        chk("f1_acc_last",  last1(v_acc), 128);
        chk("f1_acc_cnt",   cnt1(v_acc), 126);
        chk("f1_fir_done",  first1(v_fdn), 129);
        chk("f1_fir_done_cnt", cnt1(v_fdn), 1);
        chk("f1_mul_first", first1(v_mul), 130);
        chk("f1_mul_last",  last1(v_mul), 255);
        chk("f1_wwr_first", first1(v_wwr), 131);
        chk("f1_wwr_last",  last1(v_wwr), 256);
        chk("f1_wwr_cnt",   cnt1(v_wwr), 126);
        chk("f1_wwr_order", wz_seq_err, 0);
        chk("f1_done_at",   first1(v_done), 257);
        chk("f1_done_cnt",  cnt1(v_done), 1);
        chk("f1_busy_first", first1(v_busy), 1);
        chk("f1_busy_last",  last1(v_busy), 257);
        chk("f1_busy_cnt",   cnt1(v_busy), 257);
        chk("f1_wzr_tap0",   wzr_at[2], 0);
        chk("f1_wzr_tap125", wzr_at[127], 125);
        chk("f1_xn_tap1",    xn_at[3], 125);
        chk("f1_frame_cnt",  frame_cnt, 1);
        chk("l2_acc_first", first1(w_acc), 4);
        chk("l2_acc_last",  last1(w_acc), 129);
        chk("l2_fir_done",  first1(w_fdn), 130);
        chk("l2_mul_first", first1(w_mul), 132);
        chk("l2_wwr_first", first1(w_wwr), 133);
        chk("l2_wwr_last",  last1(w_wwr), 258);
        chk("l2_done_at",   first1(w_done), 259);
        chk("l2_frame_cnt", d2_frame_cnt, 1);

        // enable low in IDLE: strobe ignored, no overrun
        @(negedge clk);
        enable = 1'b0; sample_stb = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
        chk("en0_busy", busy, 0);
        @(negedge clk);
        chk("en0_busy2", busy, 0);
        chk("en0_overrun", overrun, 0);
        enable = 1'b1;

        // frame 2 (xn_base=1), enable dropped mid-frame
        @(negedge clk);
        sample_stb = 1'b1;
        capture(262, 0, 0, 0, 60);
        enable = 1'b1;
        chk("f2_xwr_addr", xn_at[1], 1);
        chk("f2_xn_t0", xn_at[2], 1);
        chk("f2_xn_t1", xn_at[3], 0);
        chk("f2_xn_t2", xn_at[4], 125);
        chk("f2_xn_t3", xn_at[5], 124);
        chk("f2_done_at", first1(v_done), 257);
        chk("f2_frame_cnt", frame_cnt, 2);

        // frame 3: strobes at +100 and +257 dropped
        @(negedge clk);
        sample_stb = 1'b1;
        capture(262, 100, 257, 0, 0);
        chk("f3_done_at", first1(v_done), 257);
        chk("f3_done_cnt", cnt1(v_done), 1);
        chk("f3_busy_last", last1(v_busy), 257);
        chk("f3_overrun", overrun, 1);
        chk("f3_frame_cnt", frame_cnt, 3);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        chk("clr_overrun", overrun, 0);

        // frame 4: clear coincident with a dropped strobe
        @(negedge clk);
        sample_stb = 1'b1;
        capture(262, 50, 0, 50, 0);
        chk("f4_overrun", overrun, 1);
        chk("f4_done_at", first1(v_done), 257);
        chk("f4_frame_cnt", frame_cnt, 4);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;

        // reset during the LMS sweep
        @(negedge clk);
        sample_stb = 1'b1;
        capture(139, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_wz_wren", wz_wren, 0);
        chk("mrst_mul_en", lms_mul_en, 0);
        chk("mrst_xn_addr", xn_addr, 0);
        chk("mrst_wz_rd_addr", wz_rd_addr, 0);
        chk("mrst_frame_cnt", frame_cnt, 0);
        wr_after = 0;
        repeat (3) begin
            @(negedge clk);
            if (wz_wren) wr_after++;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (wz_wren) wr_after++;
        end
        chk("mrst_no_wz_wren", wr_after, 0);

        // 127 back-to-back frames from xn_base=0; each next strobe lands at +258
        @(negedge clk);
        sample_stb = 1'b1;
        for (int f = 1; f <= 127; f++) begin
            capture(258, 0, (f < 127) ? 258 : 0, 0, 0);
            if (f == 1)   chk("w1_xwr_addr", xn_at[1], 0);
            if (f == 1)   chk("w1_done_at", first1(v_done), 257);
            if (f == 126) chk("w126_xwr_addr", xn_at[1], 125);
            if (f == 127) chk("w127_xwr_at", first1(v_xwr), 1);
            if (f == 127) chk("w127_xwr_addr", xn_at[1], 0);
        end
        chk("wrap_frame_cnt", frame_cnt, 127);
        chk("wrap_overrun", overrun, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
